// File: rtl/store_pkg.sv
// Shared opcode ranges and FIFO entry layout for the store buffer.
package store_pkg;

  localparam logic [4:0] OP_WORD_LO = 5'd3;
  localparam logic [4:0] OP_WORD_HI = 5'd5;
  localparam logic [4:0] OP_HALF_LO = 5'd6;
  localparam logic [4:0] OP_HALF_HI = 5'd8;
  localparam logic [4:0] OP_BYTE_LO = 5'd9;
  localparam logic [4:0] OP_BYTE_HI = 5'd11;

  typedef struct packed {
    logic [29:0] addr;  // word address, addr[31:2]
    logic [31:0] data;
    logic [3:0]  we;
  } sb_entry_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane steering: places store data into its byte lanes of an
// aligned word and produces the matching byte enables.
module store_lane_align
  import store_pkg::*;
(
  input  logic [4:0]  opcode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  output logic [31:0] data,
  output logic [3:0]  we,
  output logic        valid_op
);

  always_comb begin
    data     = '0;
    we       = '0;
    valid_op = 1'b0;
    if (opcode >= OP_WORD_LO && opcode <= OP_WORD_HI) begin
      data     = store_data;
      we       = 4'b1111;
      valid_op = 1'b1;
    end else if (opcode >= OP_HALF_LO && opcode <= OP_HALF_HI) begin
      valid_op = 1'b1;
      case (addr_lo)
        2'b00:   begin data = {16'b0, store_data[15:0]};       we = 4'b0011; end
        2'b01:   begin data = {8'b0, store_data[15:0], 8'b0};  we = 4'b0110; end
        default: begin data = {store_data[15:0], 16'b0};       we = 4'b1100; end
      endcase
    end else if (opcode >= OP_BYTE_LO && opcode <= OP_BYTE_HI) begin
      valid_op = 1'b1;
      data     = {24'b0, store_data[7:0]} << {addr_lo, 3'b000};
      we       = 4'b0001 << addr_lo;
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Aligned store FIFO draining to the data-memory write port.
// Optional store->load overlap detection: define STORE_LOAD_HAZARD_EN.
module store_buffer
  import store_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             halt,
  input  logic             bubble_in,
  input  logic             is_store,
  input  logic [4:0]       opcode,
  input  logic [31:0]      addr,
  input  logic [31:0]      store_data,
  output logic             stall_out,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic             bad_store,
  output logic             mem_wvalid,
  input  logic             mem_wready,
  output logic [31:0]      mem_waddr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_we
`ifdef STORE_LOAD_HAZARD_EN
  ,
  input  logic             is_load,
  input  logic [31:0]      load_addr,
  output logic             load_hazard
`endif
);

  sb_entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic                 bad_q, bad_d;

  logic [31:0]          al_data;
  logic [3:0]           al_we;
  logic                 al_ok;
  logic                 slot_st, enq_req, full, enq, deq;
  sb_entry_t            head;

  store_lane_align u_align (
    .opcode     (opcode),
    .addr_lo    (addr[1:0]),
    .store_data (store_data),
    .data       (al_data),
    .we         (al_we),
    .valid_op   (al_ok)
  );

  assign slot_st   = is_store & ~bubble_in & ~halt;
  assign enq_req   = slot_st & al_ok;
  assign full      = (count_q == (PTR_W+1)'(DEPTH));
  assign empty     = (count_q == '0);
  // Full refuses enqueue even when the head leaves this same edge.
  assign enq       = enq_req & ~full;
  assign deq       = ~empty & mem_wready;
  assign stall_out = enq_req & full;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(enq);
    rd_ptr_d = rd_ptr_q + PTR_W'(deq);
    count_d  = count_q + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
    bad_d    = bad_q | (slot_st & ~al_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      bad_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      bad_q    <= bad_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= '{addr: addr[31:2], data: al_data, we: al_we};
  end

  // Head fields are forced to zero while nothing is pending.
  assign head       = mem_q[rd_ptr_q];
  assign mem_wvalid = ~empty;
  assign mem_waddr  = empty ? '0 : {head.addr, 2'b00};
  assign mem_wdata  = empty ? '0 : head.data;
  assign mem_we     = empty ? '0 : head.we;
  assign count      = count_q;
  assign bad_store  = bad_q;

`ifdef STORE_LOAD_HAZARD_EN
  logic [31:0]      ld_data_unused;
  logic [3:0]       ld_we;
  logic             ld_ok;
  logic [DEPTH-1:0] hit;

  store_lane_align u_ld_align (
    .opcode     (opcode),
    .addr_lo    (load_addr[1:0]),
    .store_data ('0),
    .data       (ld_data_unused),
    .we         (ld_we),
    .valid_op   (ld_ok)
  );

  for (genvar i = 0; i < DEPTH; i++) begin : g_hit
    logic [PTR_W-1:0] off;
    logic             vld;
    // Slot i is live when its distance from the head is below the occupancy.
    assign off      = PTR_W'(i) - rd_ptr_q;
    assign vld      = ({1'b0, off} < count_q);
    assign hit[i]   = vld & (mem_q[i].addr == load_addr[31:2]) & |(mem_q[i].we & ld_we);
  end

  assign load_hazard = is_load & ~bubble_in & ld_ok & |hit;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: stimulus pushes expected writes, a
// monitor pops and compares on every memory handshake.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int PTR_W = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             halt, bubble_in, is_store, mem_wready;
  logic [4:0]       opcode;
  logic [31:0]      addr, store_data;
  logic             stall_out, empty, bad_store, mem_wvalid;
  logic [PTR_W:0]   count;
  logic [31:0]      mem_waddr, mem_wdata;
  logic [3:0]       mem_we;
`ifdef STORE_LOAD_HAZARD_EN
  logic             is_load, load_hazard;
  logic [31:0]      load_addr;
`endif

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .halt       (halt),
    .bubble_in  (bubble_in),
    .is_store   (is_store),
    .opcode     (opcode),
    .addr       (addr),
    .store_data (store_data),
    .stall_out  (stall_out),
    .empty      (empty),
    .count      (count),
    .bad_store  (bad_store),
    .mem_wvalid (mem_wvalid),
    .mem_wready (mem_wready),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we)
`ifdef STORE_LOAD_HAZARD_EN
    ,
    .is_load    (is_load),
    .load_addr  (load_addr),
    .load_hazard(load_hazard)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  w;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted write must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_wvalid === 1'b1 && mem_wready === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %h data %h we %b want none", mem_waddr, mem_wdata, mem_we);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("waddr", mem_waddr, e.a);
        chk("wdata", mem_wdata, e.d);
        chk("we", {28'b0, mem_we}, {28'b0, e.w});
      end
    end
  end

  // Called at posedge+1; offers one slot for one cycle.
  task automatic offer(input logic [4:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] ea, input logic [31:0] ed, input logic [3:0] ew,
                       input logic es, input logic acc);
    exp_t e;
    is_store = 1'b1; opcode = op; addr = a; store_data = sd;
    @(negedge clk);
    chk("stall_out", {31'b0, stall_out}, {31'b0, es});
    if (acc) begin
      e.a = ea; e.d = ed; e.w = ew;
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    is_store = 1'b0;
  endtask

  task automatic wait_empty(input int max);
    for (int i = 0; i < max && empty !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", {31'b0, empty}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; halt = 1'b0; bubble_in = 1'b0; is_store = 1'b0; mem_wready = 1'b0;
    opcode = '0; addr = '0; store_data = '0;
`ifdef STORE_LOAD_HAZARD_EN
    is_load = 1'b0; load_addr = '0;
`endif
    #12;
    chk("rst_empty", {31'b0, empty}, 32'd1);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_wvalid", {31'b0, mem_wvalid}, 32'd0);
    chk("rst_bad", {31'b0, bad_store}, 32'd0);
    chk("rst_stall", {31'b0, stall_out}, 32'd0);
    chk("rst_waddr", mem_waddr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_we", {28'b0, mem_we}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Byte store, lane 3, then latency and drain.
    mem_wready = 1'b1;
    offer(5'd9, 32'h103, 32'hAB, 32'h100, 32'hAB00_0000, 4'b1000, 1'b0, 1'b1);
    chk("lat_wvalid", {31'b0, mem_wvalid}, 32'd1);
    @(posedge clk); #1;
    chk("sb_empty", {31'b0, empty}, 32'd1);

    // Halfword/word/byte lane patterns, back to back; upper junk must be dropped.
    offer(5'd6,  32'h201, 32'hFFFF_1234, 32'h200, 32'h0012_3400, 4'b0110, 1'b0, 1'b1);
    offer(5'd7,  32'h202, 32'hFFFF_1234, 32'h200, 32'h1234_0000, 4'b1100, 1'b0, 1'b1);
    offer(5'd8,  32'h203, 32'h0000_1234, 32'h200, 32'h1234_0000, 4'b1100, 1'b0, 1'b1);
    offer(5'd4,  32'h306, 32'hDEAD_BEEF, 32'h304, 32'hDEAD_BEEF, 4'b1111, 1'b0, 1'b1);
    offer(5'd11, 32'h300, 32'h0000_0055, 32'h300, 32'h0000_0055, 4'b0001, 1'b0, 1'b1);
    offer(5'd10, 32'h301, 32'hFFFF_FF77, 32'h300, 32'h0000_7700, 4'b0010, 1'b0, 1'b1);
    wait_empty(20);

    // Fill, stall on the 5th, full blocks even with a same-cycle dequeue.
    mem_wready = 1'b0;
    for (int i = 0; i < 4; i++)
      offer(5'd3, 32'h400 + 32'(4*i), 32'h1000 + 32'(i), 32'h400 + 32'(4*i), 32'h1000 + 32'(i), 4'b1111, 1'b0, 1'b1);
    chk("full_count", {29'b0, count}, 32'd4);
    bubble_in = 1'b1;
    offer(5'd3, 32'h500, 32'h9999, 32'h0, 32'h0, 4'b0, 1'b0, 1'b0);
    bubble_in = 1'b0;
    offer(5'd3, 32'h410, 32'h1004, 32'h0, 32'h0, 4'b0, 1'b1, 1'b0);
    mem_wready = 1'b1;
    offer(5'd3, 32'h410, 32'h1004, 32'h0, 32'h0, 4'b0, 1'b1, 1'b0);
    chk("after_deq_count", {29'b0, count}, 32'd3);
    offer(5'd3, 32'h410, 32'h1004, 32'h410, 32'h1004, 4'b1111, 1'b0, 1'b1);
    wait_empty(20);

    // Simultaneous enqueue/dequeue at count 2; halt drains without enqueue.
    mem_wready = 1'b0;
    offer(5'd5, 32'h600, 32'hA0A0_0001, 32'h600, 32'hA0A0_0001, 4'b1111, 1'b0, 1'b1);
    offer(5'd5, 32'h604, 32'hA0A0_0002, 32'h604, 32'hA0A0_0002, 4'b1111, 1'b0, 1'b1);
    mem_wready = 1'b1;
    offer(5'd5, 32'h608, 32'hA0A0_0003, 32'h608, 32'hA0A0_0003, 4'b1111, 1'b0, 1'b1);
    mem_wready = 1'b0;
    chk("enq_deq_count", {29'b0, count}, 32'd2);
    halt = 1'b1; mem_wready = 1'b1;
    offer(5'd5, 32'h60C, 32'hA0A0_0004, 32'h0, 32'h0, 4'b0, 1'b0, 1'b0);
    chk("halt_count", {29'b0, count}, 32'd1);
    wait_empty(20);
    halt = 1'b0;

    // Bad opcode: no entry, sticky flag.
    offer(5'd13, 32'h700, 32'h1, 32'h0, 32'h0, 4'b0, 1'b0, 1'b0);
    chk("bad_set", {31'b0, bad_store}, 32'd1);
    chk("bad_noenq", {31'b0, empty}, 32'd1);
    offer(5'd5, 32'h50C, 32'h0BAD_F00D, 32'h50C, 32'h0BAD_F00D, 4'b1111, 1'b0, 1'b1);
    chk("bad_sticky", {31'b0, bad_store}, 32'd1);
    wait_empty(20);

`ifdef STORE_LOAD_HAZARD_EN
    mem_wready = 1'b0;
    offer(5'd9, 32'h101, 32'h66, 32'h100, 32'h0000_6600, 4'b0010, 1'b0, 1'b1);
    is_load = 1'b1; opcode = 5'd3; load_addr = 32'h100; #1;
    chk("hz_lw", {31'b0, load_hazard}, 32'd1);
    opcode = 5'd9; load_addr = 32'h102; #1;
    chk("hz_lb_other_lane", {31'b0, load_hazard}, 32'd0);
    opcode = 5'd3; load_addr = 32'h104; #1;
    chk("hz_other_word", {31'b0, load_hazard}, 32'd0);
    is_load = 1'b0;
    mem_wready = 1'b1;
    wait_empty(20);
    is_load = 1'b1; load_addr = 32'h100; #1;
    chk("hz_drained", {31'b0, load_hazard}, 32'd0);
    is_load = 1'b0;
    @(posedge clk); #1;
`endif

    // Reset mid-drain discards pending entries immediately.
    mem_wready = 1'b0;
    for (int i = 0; i < 3; i++)
      offer(5'd3, 32'h800 + 32'(4*i), 32'h77 + 32'(i), 32'h800 + 32'(4*i), 32'h77 + 32'(i), 4'b1111, 1'b0, 1'b1);
    chk("pre_rst_count", {29'b0, count}, 32'd3);
    mem_wready = 1'b1;
    rst_n = 1'b0;
    #1;
    sbq.delete();
    chk("mid_rst_empty", {31'b0, empty}, 32'd1);
    chk("mid_rst_wvalid", {31'b0, mem_wvalid}, 32'd0);
    chk("mid_rst_count", {29'b0, count}, 32'd0);
    chk("mid_rst_bad", {31'b0, bad_store}, 32'd0);
    chk("mid_rst_waddr", mem_waddr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    offer(5'd6, 32'h900, 32'hCAFE, 32'h900, 32'h0000_CAFE, 4'b0011, 1'b0, 1'b1);
    wait_empty(20);

    chk("leftover_expected", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Store-side counterpart of the load lane extraction performed at writeback.
- Accepts retiring store slots, shifts the store data into the addressed lane(s) of a 32-bit aligned word, and generates per-byte write enables.
- Queues aligned stores in a small FIFO and drains them to the data-memory write port over a valid/ready handshake.
- Sits between the memory stage and the data-memory write port; asserts a stall back to the pipeline when it is full.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, ≥2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- halt  in  1  pipeline halt; blocks enqueue only
- bubble_in  in  1  slot is a bubble; never enqueued
- is_store  in  1  slot is a store
- opcode  in  5  3..5 word, 6..8 halfword, 9..11 byte
- addr  in  32  byte address of the store
- store_data  in  32  register value; the low bits carry halfword/byte data
- stall_out  out  1  store offered while full
- empty  out  1  no pending entries
- count  out  PTR_W+1  occupied entries
- bad_store  out  1  sticky: store with opcode outside 3..11
- mem_wvalid  out  1  head entry valid
- mem_wready  in  1  memory accepts head
- mem_waddr  out  32  {addr[31:2],2'b00} of head
- mem_wdata  out  32  lane-aligned data of head
- mem_we  out  4  byte enables of head; bit i = byte i, bits [8i+7:8i]

Behaviour:
- Reset (async, rst_n low): pointers and count cleared; empty=1; count=0; mem_wvalid=0; bad_store=0; stall_out=0; mem_waddr, mem_wdata and mem_we read 0. Pending entries are discarded, including during a drain.
- enq_req = is_store & ~bubble_in & ~halt & opcode in 3..11.
- Entry is written on posedge when enq_req & ~full.
- stall_out = enq_req & full (combinational). The pipeline holds the slot and re-offers it.
- Full blocks enqueue even if a dequeue occurs the same cycle.
- deq = mem_wvalid & mem_wready; head advances on posedge.
- mem_wvalid = ~empty. Head fields come straight from the storage array and are held stable while mem_wvalid & ~mem_wready.
- Latency: a store accepted at edge N is visible on the port after edge N; earliest handshake is the next edge.
- Simultaneous enqueue and dequeue when not full: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count distinguishes full (count==DEPTH) from empty (count==0).
- Lane alignment, indexed by addr[1:0]:
  - word: data=store_data, we=4'b1111; addr[1:0] ignored.
  - half 00: data=sd[15:0] at [15:0], we=0011.
  - half 01: data=sd[15:0] at [23:8], we=0110.
  - half 1x: data=sd[15:0] at [31:16], we=1100.
  - byte k (k=addr[1:0]): data=sd[7:0] at [8k+7:8k], we=1<<k.
  - Unenabled data bits are 0.
- Bad opcode (is_store & ~bubble_in & ~halt, opcode outside 3..11): not enqueued, no stall; bad_store set until reset.
- halt does not stop draining, so memory never deadlocks.

Optional Feature:
- Macro STORE_LOAD_HAZARD_EN.
- Defined: adds inputs is_load (1) and load_addr (32), and output load_hazard (1).
- load_hazard = is_load & ~bubble_in & some valid entry with equal addr[31:2] and nonzero mem_we overlapping the load's byte lanes. Load lanes are computed with the same opcode/addr rules as stores.
- The pipeline stalls the load while load_hazard is high.
- Not defined: ports absent, no comparators; software orders loads after stores.

Decomposition:
- Package store_pkg holds:
  - opcode range constants OP_WORD_LO/HI = 3/5, OP_HALF_LO/HI = 6/8, OP_BYTE_LO/HI = 9/11;
  - typedef sb_entry_t {addr[31:2], data[31:0], we[3:0]}.
- One sub-module: store_lane_align, combinational; opcode, addr[1:0], store_data → data, we, valid_op. It is reused by the hazard lane check.

Test Plan:
- sb opcode 9, addr 0x103, sd 0xAB, mem_wready=1 → next cycle mem_waddr 0x100, mem_wdata 0xAB000000, mem_we 1000; empty after handshake.
- sh opcode 6 at addr 0x201, sd 0x1234 → wdata 0x00123400, we 0110; at 0x202 and 0x203 → 0x12340000, we 1100.
- mem_wready=0, five word stores, DEPTH=4 → count 4, stall_out on the 5th; raise mem_wready → four entries drain in order, then the 5th is accepted; pointers wrap.
- Enqueue and dequeue in the same cycle at count 2 → count stays 2; head order preserved; halt=1 with pending entries → draining continues, no enqueue.
- Store with opcode 13 → no entry, bad_store=1 and sticky; rst_n pulsed low mid-drain with 3 entries → empty=1, mem_wvalid=0 immediately.
- (STORE_LOAD_HAZARD_EN) pending sb at 0x101; lw at 0x100 → load_hazard=1; lb at 0x102 → 0; after drain → 0.
